// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: states, opcodes,
// PC control codes and ALU function codes.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_JUMP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_LDI  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_BEQZ = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake and strobe bundle between the sequencer (slave) and the
// datapath/fetch side (master).
interface multicycle_ctrl_fsm_if #(
    parameter int NUM_REGS = 4,
    parameter int RD_W     = 2
);
    logic                start;
    logic                fetch_done;
    logic                exec_done;
    logic [3:0]          opcode;
    logic [RD_W-1:0]     rd;
    logic                zero;
    logic                fetch_pulse;
    logic                exec_pulse;
    logic                pc_pulse;
    logic [1:0]          pc_ctrl;
    logic [NUM_REGS-1:0] reg_en;
    logic                alu_in_sel;
    logic [2:0]          alu_func;
    logic                busy;
    logic                err;

    modport master (
        output start, fetch_done, exec_done, opcode, rd, zero,
        input  fetch_pulse, exec_pulse, pc_pulse, pc_ctrl, reg_en,
               alu_in_sel, alu_func, busy, err
    );

    modport slave (
        input  start, fetch_done, exec_done, opcode, rd, zero,
        output fetch_pulse, exec_pulse, pc_pulse, pc_ctrl, reg_en,
               alu_in_sel, alu_func, busy, err
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// Wait-cycle counter shared by FETCH and EXEC; flags the last allowed cycle.
module multicycle_ctrl_fsm_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic active,
    input  logic done,
    output logic timeout
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (active && !done)
            cnt <= cnt + CW'(1);
    end

    // With TIMEOUT_CYC == 0 the counter free-runs but never raises the flag.
    assign timeout = (TIMEOUT_CYC != 0) && (cnt == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle instruction sequencer: IDLE->FETCH->DECODE->EXEC->WB plus
// JUMP/HALT, with registered strobes decoded from the next state.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int RD_W        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_ctrl_fsm_if.slave   bus
);
    state_t          state, next_state;
    logic [RD_W-1:0] rd_q;
    logic            illegal, timed_out, tmo;
    logic            sel_n;
    logic [2:0]      fn_n;
    logic            in_wait, wait_done, timer_clr;
    logic            enter_fetch, enter_exec, enter_jump;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [RD_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign in_wait   = (state == S_FETCH) || (state == S_EXEC);
    assign wait_done = (state == S_FETCH) ? bus.fetch_done : bus.exec_done;
    assign timer_clr = ((next_state == S_FETCH) || (next_state == S_EXEC)) && (next_state != state);

    multicycle_ctrl_fsm_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .active  (in_wait),
        .done    (wait_done),
        .timeout (tmo)
    );

    always_comb begin
        next_state = state;
        illegal    = 1'b0;
        timed_out  = 1'b0;
        sel_n      = bus.alu_in_sel;   // held while waiting in EXEC
        fn_n       = bus.alu_func;
        case (state)
            S_IDLE, S_HALT: if (bus.start) next_state = S_FETCH;
            S_FETCH: begin
                if (bus.fetch_done)
                    next_state = S_DECODE;
                else if (tmo) begin
                    next_state = S_IDLE;
                    timed_out  = 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        next_state = S_EXEC;
                        sel_n      = 1'b1;
                        fn_n       = bus.opcode[2:0];
                    end
                    OP_LDI: begin
                        next_state = S_EXEC;
                        sel_n      = 1'b0;
                        fn_n       = ALU_ADD;
                    end
                    OP_JMP:  next_state = S_JUMP;
                    OP_BEQZ: next_state = bus.zero ? S_JUMP : S_FETCH;
                    OP_HALT: next_state = S_HALT;
                    default: begin
                        next_state = S_IDLE;
                        illegal    = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                if (bus.exec_done)
                    next_state = S_WB;
                else if (tmo) begin
                    next_state = S_IDLE;
                    timed_out  = 1'b1;
                end
            end
            S_WB, S_JUMP: next_state = S_FETCH;
            default:      next_state = S_IDLE;
        endcase
    end

    assign enter_fetch = (next_state == S_FETCH) && (state != S_FETCH);
    assign enter_exec  = (next_state == S_EXEC)  && (state != S_EXEC);
    assign enter_jump  = (next_state == S_JUMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            rd_q            <= '0;
            bus.fetch_pulse <= 1'b0;
            bus.exec_pulse  <= 1'b0;
            bus.pc_pulse    <= 1'b0;
            bus.pc_ctrl     <= PC_HOLD;
            bus.reg_en      <= '0;
            bus.alu_in_sel  <= 1'b0;
            bus.alu_func    <= ALU_ADD;
            bus.busy        <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                rd_q <= bus.rd;
            bus.fetch_pulse <= enter_fetch;
            bus.exec_pulse  <= enter_exec;
            bus.pc_pulse    <= enter_fetch || enter_jump;
            bus.pc_ctrl     <= enter_fetch ? PC_INC : (enter_jump ? PC_LOAD : PC_HOLD);
            bus.reg_en      <= (next_state == S_WB) ? onehot(rd_q) : '0;
            bus.alu_in_sel  <= (next_state == S_EXEC) ? sel_n : 1'b0;
            bus.alu_func    <= (next_state == S_EXEC) ? fn_n : ALU_ADD;
            bus.busy        <= (next_state != S_IDLE) && (next_state != S_HALT);
            bus.err         <= bus.err || illegal || timed_out;
        end
    end

endmodule
